// File: rtl/ppu_pixel_capture.sv
// ppu_pixel_capture: captures one PPU frame through a FWFT pixel FIFO into a frame-buffer write port.
// Define PIXEL_CAPTURE_STATS_EN to add the frame_count/drop_count statistics outputs.
module ppu_pixel_capture #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [5:0]  color,
   input  logic [8:0]  cycle,
   input  logic [8:0]  scanline,
   input  logic        arm,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic        frame_done,
   output logic        overflow
`ifdef PIXEL_CAPTURE_STATS_EN
   ,
   output logic [15:0] frame_count,
   output logic [15:0] drop_count
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN} state_t;
   state_t        state_q, state_d;
   logic [21:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d, done_q, done_d;
   logic          in_frame, sof, push_req, pop, full, push, drop;
   assign wr_valid   = cnt_q != '0;
   assign wr_addr    = wr_valid ? mem_q[rptr_q][21:6] : 16'h0000;
   assign wr_data    = wr_valid ? {2'b00, mem_q[rptr_q][5:0]} : 8'h00;
   assign busy       = state_q != IDLE;
   assign frame_done = done_q;
   assign overflow   = ovf_q;
   always_comb begin
      in_frame = (scanline < 9'd240) && (cycle < 9'd256);
      sof      = (scanline == 9'd0) && (cycle == 9'd0);
      push_req = ce && in_frame && (state_q == CAPTURE || (state_q == WAIT_SOF && sof));
      pop      = wr_valid && wr_ready;
      full     = cnt_q == (AW+1)'(FIFO_DEPTH);
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
      wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d    = (state_q == IDLE && arm) ? 1'b0 : (ovf_q | drop);
      done_d   = (state_q == DRAIN) && (cnt_q == '0);
      state_d  = state_q;
      case (state_q)
         IDLE:     state_d = arm ? WAIT_SOF : IDLE;
         WAIT_SOF: state_d = (ce && sof) ? CAPTURE : WAIT_SOF;
         CAPTURE:  state_d = (ce && scanline == 9'd240 && cycle == 9'd0) ? DRAIN : CAPTURE;
         DRAIN:    state_d = (cnt_q == '0) ? IDLE : DRAIN;
         default:  state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end
   // Storage needs no reset: the empty FIFO masks the head onto zero outputs.
   always_ff @(posedge clk) begin
      if (!reset && push) mem_q[wptr_q] <= {scanline[7:0], cycle[7:0], color};
   end
`ifdef PIXEL_CAPTURE_STATS_EN
   logic [15:0] fcnt_q, fcnt_d, dcnt_q, dcnt_d;
   assign frame_count = fcnt_q;
   assign drop_count  = dcnt_q;
   always_comb begin
      fcnt_d = done_d ? fcnt_q + 16'd1 : fcnt_q;
      dcnt_d = (drop && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q <= '0;
         dcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         dcnt_q <= dcnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_ppu_pixel_capture.sv
// tb_ppu_pixel_capture: directed vector table plus multi-cycle sequences for ppu_pixel_capture.
module tb_ppu_pixel_capture;
   logic        clk = 1'b0;
   logic        reset, ce, arm, wr_ready;
   logic [5:0]  color;
   logic [8:0]  cycle, scanline;
   logic        wr_valid, busy, frame_done, overflow;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
`ifdef PIXEL_CAPTURE_STATS_EN
   logic [15:0] frame_count, drop_count;
`endif
   int total = 0, passed = 0;
   logic        mon_en = 1'b0;
   int          nwr = 0, nfd = 0, ord_err = 0;
   logic [15:0] exp_addr = 16'h0000;

   ppu_pixel_capture #(.FIFO_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .ce(ce), .color(color), .cycle(cycle), .scanline(scanline),
      .arm(arm), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef PIXEL_CAPTURE_STATS_EN
      , .frame_count(frame_count), .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, a, c;
      logic [8:0] sl, cy;
      logic [5:0] col;
      logic rdy;
      logic v;
      logic [15:0] ad;
      logic [7:0] d;
      logic b, fd, ov;
   } vec_t;
   vec_t tv[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   task automatic step(input logic a, input logic c, input int sl, input int cy, input int col, input logic rdy);
      arm = a; ce = c; scanline = 9'(sl); cycle = 9'(cy); color = 6'(col); wr_ready = rdy;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, 0, 0, 0, 1'b0);
      reset = 1'b0;
   endtask

   // Scoreboard for the full-frame run: writes must arrive in raster order.
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_valid && wr_ready) begin
            if (wr_addr != exp_addr || wr_data != 8'((exp_addr[15:8] + exp_addr[7:0]) & 8'h3F)) ord_err++;
            exp_addr <= exp_addr + 16'd1;
            nwr++;
         end
         if (frame_done) nfd++;
      end
   end

   initial begin
      int fd_seen;
      reset = 1'b1; ce = 1'b0; arm = 1'b0; wr_ready = 1'b0;
      color = '0; cycle = '0; scanline = '0;
      //        rst   arm   ce    sl       cy       col     rdy  | v     addr      data   busy  fd    ov
      tv[0]  = '{1'b1, 1'b0, 1'b0, 9'd0,   9'd0,   6'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
      tv[1]  = '{1'b0, 1'b0, 1'b1, 9'd0,   9'd0,   6'h11, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 9'd0,   9'd0,   6'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 1'b0, 1'b1, 9'd5,   9'd5,   6'h11, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 1'b0, 1'b1, 9'd0,   9'd0,   6'h11, 1'b0, 1'b1, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b0};
      tv[5]  = '{1'b0, 1'b0, 1'b1, 9'd3,   9'd17,  6'h2A, 1'b0, 1'b1, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b0};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   6'h00, 1'b1, 1'b1, 16'h0311, 8'h2A, 1'b1, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 1'b0, 1'b1, 9'd3,   9'd300, 6'h3F, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[8]  = '{1'b0, 1'b0, 1'b1, 9'd250, 9'd10,  6'h3F, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 1'b0, 1'b1, 9'd3,   9'd17,  6'h2A, 1'b1, 1'b1, 16'h0311, 8'h2A, 1'b1, 1'b0, 1'b0};
      tv[10] = '{1'b0, 1'b1, 1'b1, 9'd239, 9'd255, 6'h05, 1'b1, 1'b1, 16'hEFFF, 8'h05, 1'b1, 1'b0, 1'b0};
      tv[11] = '{1'b0, 1'b0, 1'b1, 9'd240, 9'd0,   6'h07, 1'b0, 1'b1, 16'hEFFF, 8'h05, 1'b1, 1'b0, 1'b0};
      tv[12] = '{1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   6'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[13] = '{1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   6'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};
      tv[14] = '{1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   6'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
      tv[15] = '{1'b0, 1'b0, 1'b1, 9'd0,   9'd0,   6'h01, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 16; i++) begin
         reset = tv[i].rst;
         step(tv[i].a, tv[i].c, int'(tv[i].sl), int'(tv[i].cy), int'(tv[i].col), tv[i].rdy);
         chk($sformatf("v%0d_valid", i), 32'(wr_valid), 32'(tv[i].v));
         chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(tv[i].ad));
         chk($sformatf("v%0d_data", i), 32'(wr_data), 32'(tv[i].d));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].b));
         chk($sformatf("v%0d_done", i), 32'(frame_done), 32'(tv[i].fd));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tv[i].ov));
      end

      // Stalled sink: 16 pixels fill the FIFO, the 17th is dropped.
      do_reset();
      step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      for (int c = 0; c < 16; c++) step(1'b0, 1'b1, 0, c, c, 1'b0);
      chk("fill_ovf", 32'(overflow), 32'd0);
      chk("fill_head", 32'(wr_addr), 32'h0000);
      step(1'b0, 1'b1, 0, 16, 16, 1'b0);
      chk("drop_ovf", 32'(overflow), 32'd1);
`ifdef PIXEL_CAPTURE_STATS_EN
      chk("drop_count", 32'(drop_count), 32'd1);
`endif
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain%0d_addr", k), 32'(wr_addr), 32'(k));
         chk($sformatf("drain%0d_data", k), 32'(wr_data), 32'(k));
         step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      end
      chk("drain_empty", 32'(wr_valid), 32'd0);

      // Full FIFO with simultaneous pop: accepted, then a stalled push proves it is still full.
      do_reset();
      step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      chk("rearm_ovf_clear", 32'(overflow), 32'd0);
      for (int c = 0; c < 16; c++) step(1'b0, 1'b1, 0, c, c, 1'b0);
      step(1'b0, 1'b1, 0, 16, 16, 1'b1);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(wr_addr), 32'h0001);
      step(1'b0, 1'b1, 0, 17, 17, 1'b0);
      chk("pp_full_ovf", 32'(overflow), 32'd1);

      // Armed but no pixels arriving: busy with no writes.
      do_reset();
      step(1'b1, 1'b0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      chk("noce_busy", 32'(busy), 32'd1);
      chk("noce_valid", 32'(wr_valid), 32'd0);

      // Reset mid-capture at scanline 100 dominates arm and ce.
      do_reset();
      step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      step(1'b0, 1'b1, 0, 0, 1, 1'b0);
      for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 100, c, 2, 1'b0);
      chk("pre_rst_valid", 32'(wr_valid), 32'd1);
      reset = 1'b1;
      step(1'b1, 1'b1, 100, 5, 3, 1'b0);
      reset = 1'b0;
      chk("rst_valid", 32'(wr_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      fd_seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (frame_done) fd_seen++;
         step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      end
      chk("rst_no_done", 32'(fd_seen), 32'd0);

      // Full frame, sink always ready, with a few off-screen dots per line.
      do_reset();
      step(1'b1, 1'b0, 0, 0, 0, 1'b1);
      mon_en = 1'b1;
      for (int s = 0; s < 240; s++)
         for (int c = 0; c < 260; c++) step(1'b0, 1'b1, s, c, (s + c) & 63, 1'b1);
      step(1'b0, 1'b1, 240, 0, 0, 1'b1);
      for (int k = 0; k < 50 && busy; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      chk("frame_drain_timeout", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      mon_en = 1'b0;
      chk("frame_writes", 32'(nwr), 32'd61440);
      chk("frame_order", 32'(ord_err), 32'd0);
      chk("frame_last_addr", 32'(exp_addr), 32'hF000);
      chk("frame_done_cnt", 32'(nfd), 32'd1);
      chk("frame_ovf", 32'(overflow), 32'd0);
`ifdef PIXEL_CAPTURE_STATS_EN
      chk("frame_count", 32'(frame_count), 32'd1);
      chk("frame_drops", 32'(drop_count), 32'd0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
